alu_param: RTL and testbench
============================

ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter IMM_W, default 12, giving the immediate width; the immediate is two's-complement.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, the operation request.
REQ-006 SHALL have port alucontrol, input, 4 bits, the operation code (see REQ-014).
REQ-007 SHALL have port alusrc, input, 1 bit: 1 selects the sign-extended imediato as operand B, 0 selects ler_dados2.
REQ-008 SHALL have ports ler_dados1 and ler_dados2, input, WIDTH bits each: operands A and B.
REQ-009 SHALL have port imediato, input, IMM_W bits, sign-extended to WIDTH; there is no separate sign flag.
REQ-010 SHALL have port branch, input, 1 bit, the branch-instruction qualifier.
REQ-011 SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle pulse marking that results are valid.
REQ-013 SHALL have outputs aluresult, WIDTH bits; cond, 1 bit (branch condition); pcsrc, 1 bit; ilegal, 1 bit (undefined opcode).

Function
REQ-014 Opcodes SHALL be:
- 0000 AND, 0001 OR, 0100 XOR
- 0010 ADD, 0110 SUB
- 1010 SLL, 0111 SRL, 0101 SRA
- 1011 SLT, 1100 SLTU
- 1000 BEQ, 1111 BNE, 1101 BLT, 1110 BGE
- 0011 MUL
- 1001 undefined.
REQ-015 An operation SHALL be accepted on a rising edge where start=1 and busy=0; operands, opcode, alusrc and branch are captured at that edge.
REQ-016 A start while busy=1 SHALL be ignored without side effects.
REQ-017 Non-MUL ops SHALL register their results at the accepting edge; done=1 for the following cycle; busy stays 0.
REQ-018 Back-to-back single-cycle ops SHALL sustain 1 op/cycle.
REQ-019 The FSM SHALL have states IDLE and MUL.
- IDLE->MUL on an accepted MUL op; busy=1 while in MUL.
- MUL runs WIDTH shift-add iterations, tracked by a down-counter.
- MUL->IDLE after the last iteration; that edge registers aluresult and produces done=1 for one cycle.
REQ-020 MUL SHALL return the low WIDTH bits of the product, with wrap-around.
REQ-021 A start arriving in the cycle done=1 SHALL be accepted normally.
REQ-022 All arithmetic SHALL be modulo 2^WIDTH.
- SLT/BLT/BGE are signed; SLTU is unsigned.
- Shift amount is B[log2(WIDTH)-1:0]; upper bits are ignored.
- SRA replicates bit WIDTH-1.
REQ-023 Branch ops SHALL set aluresult=A-B and cond=comparison result; all other ops set cond=0.
REQ-024 pcsrc SHALL equal cond AND the captured branch.
REQ-025 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH.
REQ-026 Opcode 1001 SHALL set ilegal=1, aluresult=0, cond=0, with normal done timing; any other op clears ilegal.
REQ-027 aluresult, cond, pcsrc and ilegal SHALL hold their values until the next done.

Reset
REQ-028 While reset=1 at a rising edge, the following SHALL be forced:
- state to IDLE, iteration counter to 0
- busy, done, cond, pcsrc, ilegal to 0
- aluresult to 0.
REQ-029 Reset mid-MUL SHALL abort the operation with no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro ALU_PARAM_MUL_EN SHALL control the multiplier.
- Defined: MUL is implemented per REQ-019/020.
- Undefined: no multiplier or counter logic is synthesised; opcode 0011 is treated as undefined per REQ-026 (single-cycle, ilegal=1); busy is tied to 0.

Verification (WIDTH=32, IMM_W=12)
REQ-031 ADD, alusrc=1, A=10, imediato=0xFFB -> aluresult=5, done pulses 1 cycle after accept, busy=0.
REQ-032 BLT, A=0xFFFF_FFFF, B=1, branch=1 -> cond=1, pcsrc=1; the same operands with SLTU -> aluresult=0, cond=0.
REQ-033 SRA, A=0x8000_0000, B=33 -> aluresult=0xC000_0000; SRL with the same operands -> 0x4000_0000.
REQ-034 MUL, A=0x0001_0003, B=5 -> aluresult=0x0005_000F, done 33 clocks after accept, busy=1 in between; a start with ADD during busy is ignored.
REQ-035 MUL accepted, then reset=1 at iteration 10 -> next cycle busy=0, aluresult=0, no done; a following ADD completes normally.
REQ-036 Build without ALU_PARAM_MUL_EN, op=0011 -> done after 1 cycle, ilegal=1, aluresult=0, busy never asserted.

Source files
------------

// File: rtl/alu_param.sv
// Parameterised ALU with single-cycle ops and an optional shift-add multiplier.
// Define ALU_PARAM_MUL_EN to build the multiplier; otherwise opcode 0011 reports ilegal.
module alu_param #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic             alusrc,
    input  logic [WIDTH-1:0] ler_dados1,
    input  logic [WIDTH-1:0] ler_dados2,
    input  logic [IMM_W-1:0] imediato,
    input  logic             branch,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluresult,
    output logic             cond,
    output logic             pcsrc,
    output logic             ilegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_BLT  = 4'b1101;
    localparam logic [3:0] OP_BGE  = 4'b1110;
    localparam logic [3:0] OP_BNE  = 4'b1111;

    logic [WIDTH-1:0] aluresult_q, aluresult_d;
    logic             cond_q, cond_d;
    logic             pcsrc_q, pcsrc_d;
    logic             ilegal_q, ilegal_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             lt_s, lt_u;
    logic [WIDTH-1:0] op_res;
    logic             op_cond;
    logic             op_ill;
    logic             accept;

`ifdef ALU_PARAM_MUL_EN
    localparam int CNT_W = SHW + 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_sum;
    logic             op_is_mul;

    assign busy = (state_q == MUL);
`else
    assign busy = 1'b0;
`endif

    assign accept  = start && !busy;
    assign imm_ext = WIDTH'($signed(imediato));

    always_comb begin
        op_b    = alusrc ? imm_ext : ler_dados2;
        shamt   = op_b[SHW-1:0];
        diff    = ler_dados1 - op_b;
        lt_s    = $signed(ler_dados1) < $signed(op_b);
        lt_u    = ler_dados1 < op_b;
        op_res  = '0;
        op_cond = 1'b0;
        op_ill  = 1'b0;
`ifdef ALU_PARAM_MUL_EN
        op_is_mul = 1'b0;
`endif
        case (alucontrol)
            OP_AND:  op_res = ler_dados1 & op_b;
            OP_OR:   op_res = ler_dados1 | op_b;
            OP_XOR:  op_res = ler_dados1 ^ op_b;
            OP_ADD:  op_res = ler_dados1 + op_b;
            OP_SUB:  op_res = diff;
            OP_SLL:  op_res = ler_dados1 << shamt;
            OP_SRL:  op_res = ler_dados1 >> shamt;
            OP_SRA:  op_res = WIDTH'($signed(ler_dados1) >>> shamt);
            OP_SLT:  op_res = WIDTH'(lt_s);
            OP_SLTU: op_res = WIDTH'(lt_u);
            OP_BEQ:  begin op_res = diff; op_cond = (diff == '0); end
            OP_BNE:  begin op_res = diff; op_cond = (diff != '0); end
            OP_BLT:  begin op_res = diff; op_cond = lt_s;         end
            OP_BGE:  begin op_res = diff; op_cond = !lt_s;        end
`ifdef ALU_PARAM_MUL_EN
            OP_MUL:  op_is_mul = 1'b1;
`else
            OP_MUL:  op_ill = 1'b1;
`endif
            default: op_ill = 1'b1;
        endcase
    end

    // Result registers only change on a completing operation, so they hold between dones.
    always_comb begin
        aluresult_d = aluresult_q;
        cond_d      = cond_q;
        pcsrc_d     = pcsrc_q;
        ilegal_d    = ilegal_q;
        done_d      = 1'b0;
`ifdef ALU_PARAM_MUL_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (accept && op_is_mul) begin
            state_d  = MUL;
            cnt_d    = CNT_W'(WIDTH);
            mcand_d  = ler_dados1;
            mplier_d = op_b;
            acc_d    = '0;
        end else if (accept) begin
`else
        if (accept) begin
`endif
            aluresult_d = op_res;
            cond_d      = op_cond;
            pcsrc_d     = op_cond && branch;
            ilegal_d    = op_ill;
            done_d      = 1'b1;
        end
`ifdef ALU_PARAM_MUL_EN
        if (state_q == MUL) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d     = IDLE;
                aluresult_d = acc_sum;
                cond_d      = 1'b0;
                pcsrc_d     = 1'b0;
                ilegal_d    = 1'b0;
                done_d      = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aluresult_q <= '0;
            cond_q      <= 1'b0;
            pcsrc_q     <= 1'b0;
            ilegal_q    <= 1'b0;
            done_q      <= 1'b0;
`ifdef ALU_PARAM_MUL_EN
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            aluresult_q <= aluresult_d;
            cond_q      <= cond_d;
            pcsrc_q     <= pcsrc_d;
            ilegal_q    <= ilegal_d;
            done_q      <= done_d;
`ifdef ALU_PARAM_MUL_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign aluresult = aluresult_q;
    assign cond      = cond_q;
    assign pcsrc     = pcsrc_q;
    assign ilegal    = ilegal_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_param.sv
// Directed self-checking bench for alu_param at WIDTH=32, IMM_W=12.
// MUL scenarios follow the ALU_PARAM_MUL_EN build setting.
module tb_alu_param;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_ILL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_BLT  = 4'b1101;
    localparam logic [3:0] OP_BGE  = 4'b1110;
    localparam logic [3:0] OP_BNE  = 4'b1111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alucontrol;
    logic        alusrc;
    logic [31:0] ler_dados1;
    logic [31:0] ler_dados2;
    logic [11:0] imediato;
    logic        branch;
    logic        busy;
    logic        done;
    logic [31:0] aluresult;
    logic        cond;
    logic        pcsrc;
    logic        ilegal;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [11:0] imm;
        logic        src;
        logic        br;
        logic [31:0] res;
        logic        cnd;
        logic        pc;
    } vec_t;

    alu_param #(.WIDTH(32), .IMM_W(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .alusrc     (alusrc),
        .ler_dados1 (ler_dados1),
        .ler_dados2 (ler_dados2),
        .imediato   (imediato),
        .branch     (branch),
        .busy       (busy),
        .done       (done),
        .aluresult  (aluresult),
        .cond       (cond),
        .pcsrc      (pcsrc),
        .ilegal     (ilegal)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [11:0] imm, input logic src, input logic br);
        alucontrol = op;
        ler_dados1 = a;
        ler_dados2 = b;
        imediato   = imm;
        alusrc     = src;
        branch     = br;
        start      = 1'b1;
    endtask

    // Drives one request for a single edge, then samples just after that edge.
    task automatic accept_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [11:0] imm, input logic src, input logic br);
        drive(op, a, b, imm, src, br);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        accept_op(OP_BEQ, 32'd9, 32'd9, 12'd0, 1'b0, 1'b1);
        drive(OP_ADD, 32'd1, 32'd1, 12'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        tests_run++;
        if ({busy, done, cond, pcsrc, ilegal} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, cond, pcsrc, ilegal});
        end
        tests_run++;
        if (aluresult !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_result: got %h expected 00000000", aluresult);
        end
    endtask

    task automatic test_add_imm();
        accept_op(OP_ADD, 32'd10, 32'hDEAD_BEEF, 12'hFFB, 1'b1, 1'b0);
        tests_run++;
        if (aluresult !== 32'd5 || done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL add_imm: got res=%h done=%b busy=%b expected res=00000005 done=1 busy=0",
                     aluresult, done, busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || aluresult !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL add_hold: got done=%b res=%h expected done=0 res=00000005", done, aluresult);
        end
    endtask

    task automatic test_ops();
        vec_t vecs [0:19];
        vecs = '{
            '{OP_BLT,  32'hFFFF_FFFF, 32'd1,          12'd0,   1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1},
            '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,          12'd0,   1'b0, 1'b1, 32'h0,         1'b0, 1'b0},
            '{OP_SRA,  32'h8000_0000, 32'd33,         12'd0,   1'b0, 1'b0, 32'hC000_0000, 1'b0, 1'b0},
            '{OP_SRL,  32'h8000_0000, 32'd33,         12'd0,   1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0},
            '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF,  12'd0,   1'b0, 1'b0, 32'h00F0_1234, 1'b0, 1'b0},
            '{OP_OR,   32'hF000_0000, 32'h0000_000F,  12'd0,   1'b0, 1'b0, 32'hF000_000F, 1'b0, 1'b0},
            '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F,  12'd0,   1'b0, 1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0},
            '{OP_SUB,  32'd5,         32'd7,          12'd0,   1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0},
            '{OP_ADD,  32'hFFFF_FFFF, 32'd1,          12'd0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0},
            '{OP_SLL,  32'd1,         32'h25,         12'd0,   1'b0, 1'b0, 32'h20,        1'b0, 1'b0},
            '{OP_SLT,  32'hFFFF_FFFE, 32'd3,          12'd0,   1'b0, 1'b0, 32'd1,         1'b0, 1'b0},
            '{OP_SLTU, 32'hFFFF_FFFE, 32'd3,          12'd0,   1'b0, 1'b0, 32'd0,         1'b0, 1'b0},
            '{OP_BEQ,  32'd7,         32'd7,          12'd0,   1'b0, 1'b1, 32'h0,         1'b1, 1'b1},
            '{OP_BNE,  32'd7,         32'd7,          12'd0,   1'b0, 1'b1, 32'h0,         1'b0, 1'b0},
            '{OP_BGE,  32'hFFFF_FFFF, 32'd1,          12'd0,   1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
            '{OP_BGE,  32'd5,         32'd5,          12'd0,   1'b0, 1'b0, 32'h0,         1'b1, 1'b0},
            '{OP_SRA,  32'h7000_0000, 32'd4,          12'd0,   1'b0, 1'b0, 32'h0700_0000, 1'b0, 1'b0},
            '{OP_SRL,  32'h8000_0000, 32'd31,         12'd0,   1'b0, 1'b0, 32'h1,         1'b0, 1'b0},
            '{OP_SRA,  32'h8000_0000, 32'd31,         12'd0,   1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0},
            '{OP_ADD,  32'd1,         32'hFFFF_FFFF,  12'h7FF, 1'b1, 1'b0, 32'h800,       1'b0, 1'b0}
        };
        for (int i = 0; i < 20; i++) begin
            accept_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, vecs[i].br);
            tests_run++;
            if (aluresult !== vecs[i].res || cond !== vecs[i].cnd || pcsrc !== vecs[i].pc ||
                done !== 1'b1 || ilegal !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL op_vec%0d: got res=%h cond=%b pcsrc=%b done=%b ilegal=%b expected res=%h cond=%b pcsrc=%b done=1 ilegal=0",
                         i, aluresult, cond, pcsrc, done, ilegal, vecs[i].res, vecs[i].cnd, vecs[i].pc);
            end
        end
    endtask

    task automatic test_illegal();
        accept_op(OP_ILL, 32'd5, 32'd6, 12'd0, 1'b0, 1'b1);
        tests_run++;
        if (ilegal !== 1'b1 || aluresult !== 32'h0 || cond !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL illegal_op: got ilegal=%b res=%h cond=%b done=%b expected 1 00000000 0 1",
                     ilegal, aluresult, cond, done);
        end
        accept_op(OP_ADD, 32'd1, 32'd2, 12'd0, 1'b0, 1'b0);
        tests_run++;
        if (ilegal !== 1'b0 || aluresult !== 32'd3) begin
            tests_failed++;
            $display("[TB] FAIL illegal_clear: got ilegal=%b res=%h expected 0 00000003", ilegal, aluresult);
        end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 32'd100, 32'd23, 12'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b1 || aluresult !== 32'd123) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got done=%b res=%h expected 1 0000007b", done, aluresult);
        end
        drive(OP_BNE, 32'd4, 32'd3, 12'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b1 || aluresult !== 32'd1 || cond !== 1'b1 || pcsrc !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got done=%b res=%h cond=%b pcsrc=%b expected 1 00000001 1 1",
                     done, aluresult, cond, pcsrc);
        end
        drive(OP_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 12'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        ler_dados1 = 32'd0;
        tests_run++;
        if (done !== 1'b1 || aluresult !== 32'hFFFF_FFFF || cond !== 1'b0 || pcsrc !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_third: got done=%b res=%h cond=%b pcsrc=%b expected 1 ffffffff 0 0",
                     done, aluresult, cond, pcsrc);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || aluresult !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold: got done=%b res=%h expected 0 ffffffff", done, aluresult);
        end
    endtask

`ifdef ALU_PARAM_MUL_EN
    task automatic test_mul();
        accept_op(OP_ADD, 32'd40, 32'd2, 12'd0, 1'b0, 1'b0);
        accept_op(OP_MUL, 32'h0001_0003, 32'd5, 12'd0, 1'b0, 1'b0);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || aluresult !== 32'd42) begin
            tests_failed++;
            $display("[TB] FAIL mul_start: got busy=%b done=%b res=%h expected 1 0 0000002a", busy, done, aluresult);
        end
        for (int k = 1; k <= 32; k++) begin
            if (k == 5) drive(OP_ADD, 32'd1, 32'd1, 12'd0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            start = 1'b0;
            tests_run++;
            if (busy !== (k < 32) || done !== (k == 32)) begin
                tests_failed++;
                $display("[TB] FAIL mul_cycle%0d: got busy=%b done=%b expected busy=%b done=%b",
                         k, busy, done, k < 32, k == 32);
            end
        end
        tests_run++;
        if (aluresult !== 32'h0005_000F || ilegal !== 1'b0 || cond !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_result: got res=%h ilegal=%b cond=%b expected 0005000f 0 0",
                     aluresult, ilegal, cond);
        end
        accept_op(OP_SUB, 32'd10, 32'd4, 12'd0, 1'b0, 1'b0);
        tests_run++;
        if (done !== 1'b1 || aluresult !== 32'd6) begin
            tests_failed++;
            $display("[TB] FAIL mul_then_op: got done=%b res=%h expected 1 00000006", done, aluresult);
        end
        accept_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'd0, 1'b0, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b1 || aluresult !== 32'd1) begin
            tests_failed++;
            $display("[TB] FAIL mul_wrap: got done=%b res=%h expected 1 00000001", done, aluresult);
        end
    endtask

    task automatic test_mul_reset();
        int done_seen = 0;
        accept_op(OP_MUL, 32'd7, 32'd9, 12'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || aluresult !== 32'h0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_reset: got busy=%b res=%h done=%b expected 0 00000000 0", busy, aluresult, done);
        end
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL mul_reset_nodone: got %0d done pulses expected 0", done_seen);
        end
        accept_op(OP_ADD, 32'd2, 32'd3, 12'd0, 1'b0, 1'b0);
        tests_run++;
        if (done !== 1'b1 || aluresult !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL mul_reset_add: got done=%b res=%h expected 1 00000005", done, aluresult);
        end
    endtask
`else
    task automatic test_mul_disabled();
        accept_op(OP_MUL, 32'd3, 32'd5, 12'd0, 1'b0, 1'b0);
        tests_run++;
        if (done !== 1'b1 || ilegal !== 1'b1 || aluresult !== 32'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mul_disabled: got done=%b ilegal=%b res=%h busy=%b expected 1 1 00000000 0",
                     done, ilegal, aluresult, busy);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || ilegal !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mul_disabled_after: got busy=%b done=%b ilegal=%b expected 0 0 1", busy, done, ilegal);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        alucontrol = 4'b0;
        alusrc     = 1'b0;
        ler_dados1 = '0;
        ler_dados2 = '0;
        imediato   = '0;
        branch     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run++;
        if ({busy, done, cond, pcsrc, ilegal} !== 5'b0 || aluresult !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL power_on_reset: got flags=%b res=%h expected 00000 00000000",
                     {busy, done, cond, pcsrc, ilegal}, aluresult);
        end
        test_add_imm();
        test_ops();
        test_illegal();
        test_back_to_back();
        test_reset();
`ifdef ALU_PARAM_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
